approx_mult_pipe: RTL and testbench

Parametrised, pipelined W×W approximate multiplier with run-time approximation control. It is the successor to the fixed 8×8 quadrant multipliers in the FPGA approximate-multiplier library. Each operand is split into H = W/2 halves to form four quadrant products, and each quadrant is individually selectable per transaction as exact or truncated. The final sum is exact or uses a lower-part-OR adder. A valid/ready stream interface with backpressure lets it drop into accelerator datapaths.

---
 rtl/approx_mult_pkg.sv | 23 ++
 rtl/approx_quad_mult.sv | 24 ++
 rtl/approx_mult_pipe.sv | 152 +++++++++++++++
 tb/tb_approx_mult_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants and helpers for the approximate multiplier
// Contents:
//   Q_LL/Q_LH/Q_HL/Q_HH  quadrant indices (A half x B half)
//   NQ                   number of quadrants
//   term_shift()         left shift that aligns a quadrant product in the full result
package approx_mult_pkg;

  localparam int Q_LL = 0;  // A_lo x B_lo
  localparam int Q_LH = 1;  // A_lo x B_hi
  localparam int Q_HL = 2;  // A_hi x B_lo
  localparam int Q_HH = 3;  // A_hi x B_hi
  localparam int NQ   = 4;

  // Cross products sit one half up, the high x high product two halves up.
  function automatic int term_shift(input int q, input int h);
    int sh;
    sh = h;
    if (q == Q_LL) sh = 0;
    if (q == Q_HH) sh = 2 * h;
    return sh;
  endfunction

endpackage

// File: rtl/approx_quad_mult.sv
// rtl/approx_quad_mult.sv - one H x H quadrant product with optional low-bit truncation
// Ports:
//   a       in  H    operand half from A
//   b       in  H    operand half from B
//   approx  in  1    1 = zero the low TRUNC bits of the product
//   p       out 2H   quadrant product
module approx_quad_mult #(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam logic [2*H-1:0] KEEP_MASK = {(2*H){1'b1}} << TRUNC;

  logic [2*H-1:0] full;

  assign full = (2*H)'(a) * (2*H)'(b);
  assign p    = approx ? (full & KEEP_MASK) : full;

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - three-stage W x W approximate multiplier with valid/ready stream
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    in  1    input transaction valid
//   in_ready    out 1    input accepted this cycle
//   in_a, in_b  in  W    operands
//   in_mode     in  4    per-quadrant truncation enable (index = quadrant)
//   in_loa      in  1    1 = lower-part-OR final adder
//   out_valid   out 1    result valid
//   out_ready   in  1    downstream accepts result
//   out_r       out 2W   product
//   approx_cnt  out 32   delivered results that had any approximation enabled
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W        = 8,
  parameter int TRUNC    = 2,
  parameter int LOA_BITS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [3:0]      in_mode,
  input  logic            in_loa,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_r,
  output logic [31:0]     approx_cnt
);

  localparam int H  = W / 2;
  localparam int RW = 2 * W;
  // Selects the result bits formed by OR in LOA mode; all-zero when LOA_BITS = 0.
  localparam logic [RW-1:0] LOA_MASK = ~({RW{1'b1}} << LOA_BITS);

  // One stall signal for the whole pipe: everything moves unless the output is blocked.
  logic en;

  // S1: operands and controls
  logic           v1_q;
  logic [W-1:0]   a_q, b_q;
  logic [3:0]     mode_q;
  logic           loa1_q;

  // S2: quadrant products
  logic           v2_q;
  logic [2*H-1:0] p_d [NQ];
  logic [2*H-1:0] p_q [NQ];
  logic           loa2_q;
  logic           apx2_q;

  // S3: result
  logic           v3_q;
  logic           apx3_q;
  logic [RW-1:0]  r_d, r_q;
  logic [31:0]    cnt_d, cnt_q;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en && !rst;
  assign out_valid = v3_q;
  assign out_r     = r_q;
  assign approx_cnt = cnt_q;

  // Quadrant q takes A's high half when q[1] is set and B's high half when q[0] is set.
  for (genvar gq = 0; gq < NQ; gq++) begin : g_quad
    localparam int A_OFS = (gq / 2) * H;
    localparam int B_OFS = (gq % 2) * H;

    approx_quad_mult #(
      .H     (H),
      .TRUNC (TRUNC)
    ) u_quad (
      .a      (a_q[A_OFS +: H]),
      .b      (b_q[B_OFS +: H]),
      .approx (mode_q[gq]),
      .p      (p_d[gq])
    );
  end

  // Final adder: exact sum, or OR'd low part with an independent high-part sum.
  always_comb begin
    logic [RW-1:0] term;
    logic [RW-1:0] exact_sum;
    logic [RW-1:0] hi_sum;
    logic [RW-1:0] lo_or;
    term      = '0;
    exact_sum = '0;
    hi_sum    = '0;
    lo_or     = '0;
    for (int q = 0; q < NQ; q++) begin
      term      = RW'(p_q[q]) << term_shift(q, H);
      exact_sum = exact_sum + term;
      hi_sum    = hi_sum + (term >> LOA_BITS);
      lo_or     = lo_or | term;
    end
    r_d = loa2_q ? ((hi_sum << LOA_BITS) | (lo_or & LOA_MASK)) : exact_sum;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && out_ready && apx3_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      loa1_q <= 1'b0;
      v2_q   <= 1'b0;
      for (int q = 0; q < NQ; q++) begin
        p_q[q] <= '0;
      end
      loa2_q <= 1'b0;
      apx2_q <= 1'b0;
      v3_q   <= 1'b0;
      apx3_q <= 1'b0;
      r_q    <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        v1_q   <= in_valid && in_ready;
        a_q    <= in_a;
        b_q    <= in_b;
        mode_q <= in_mode;
        loa1_q <= in_loa;

        v2_q <= v1_q;
        for (int q = 0; q < NQ; q++) begin
          p_q[q] <= p_d[q];
        end
        loa2_q <= loa1_q;
        apx2_q <= (mode_q != 4'd0) || loa1_q;

        v3_q   <= v2_q;
        apx3_q <= apx2_q;
        // Bubbles advance the valid bit but leave the last result on out_r.
        if (v2_q) begin
          r_q <= r_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - self-checking bench for approx_mult_pipe
module tb_approx_mult_pipe;

  localparam int W        = 8;
  localparam int TRUNC    = 2;
  localparam int LOA_BITS = 6;
  localparam int H        = W / 2;
  localparam int RW       = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_mode;
  logic          in_loa;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_r;
  logic [31:0]   approx_cnt;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  bit            ap_q[$];
  logic [31:0]   exp_cnt;

  approx_mult_pipe #(
    .W        (W),
    .TRUNC    (TRUNC),
    .LOA_BITS (LOA_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_loa     (in_loa),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .approx_cnt (approx_cnt)
  );

  always #5 clk = ~clk;

  // Reference: split into halves arithmetically, truncate by rounding down to 2^TRUNC,
  // weight by powers of 2^H, then add exactly or as OR-low / sum-high.
  function automatic logic [RW-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] mode, input logic loa);
    int unsigned half, gran, split, ai, bi, sum, lo, hi;
    int unsigned p[4];
    int unsigned t[4];
    half  = 2 ** H;
    gran  = 2 ** TRUNC;
    split = 2 ** LOA_BITS;
    ai    = 32'(a);
    bi    = 32'(b);
    p[0]  = (ai % half) * (bi % half);
    p[1]  = (ai % half) * (bi / half);
    p[2]  = (ai / half) * (bi % half);
    p[3]  = (ai / half) * (bi / half);
    for (int q = 0; q < 4; q++) begin
      if (mode[q]) p[q] = p[q] - (p[q] % gran);
    end
    t[0] = p[0];
    t[1] = p[1] * half;
    t[2] = p[2] * half;
    t[3] = p[3] * half * half;
    sum = 0;
    lo  = 0;
    hi  = 0;
    for (int q = 0; q < 4; q++) begin
      sum = sum + t[q];
      lo  = lo | (t[q] % split);
      hi  = hi + (t[q] / split);
    end
    return loa ? RW'(hi * split + lo) : RW'(sum);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge with the pipe empty and out_ready = 1.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] mode, input logic loa);
    logic [RW-1:0] e;
    e        = ref_mult(a, b, mode, loa);
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_loa   = loa;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(out_valid), 64'(k == 3));
    end
    chk({tag, "_r"}, 64'(out_r), 64'(e));
    if (mode != 4'd0 || loa) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    chk({tag, "_cnt"}, 64'(approx_cnt), 64'(exp_cnt));
    @(negedge clk);
  endtask

  initial begin
    bit            stall_prev;
    logic [RW-1:0] prev_r;
    logic [RW-1:0] e;
    bit            ap;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = '0;
    in_loa    = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_cnt", 64'(approx_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed cases with hand-computed products
    run_one("exact", 8'hFF, 8'hFF, 4'b0000, 1'b0);
    chk("exact_const", 64'(out_r), 64'hFE01);
    run_one("trunc", 8'hFF, 8'hFF, 4'b1100, 1'b0);
    chk("trunc_const", 64'(out_r), 64'hFCF1);
    chk("trunc_cnt_const", 64'(approx_cnt), 64'd1);
    run_one("loa", 8'hFF, 8'hFF, 4'b0000, 1'b1);
    chk("loa_const", 64'(out_r), 64'hFDF1);
    run_one("follow", 8'h12, 8'h34, 4'b0000, 1'b0);
    chk("follow_const", 64'(out_r), 64'h03A8);

    // Random streaming with random backpressure
    stall_prev = 1'b0;
    prev_r     = '0;
    for (int c = 0; c < 400; c++) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_r", 64'(out_r), 64'(prev_r));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_mode   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      in_loa    = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_output", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          ap = ap_q.pop_front();
          chk("stream_r", 64'(out_r), 64'(e));
          if (ap) exp_cnt = exp_cnt + 32'd1;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mult(in_a, in_b, in_mode, in_loa));
        ap_q.push_back((in_mode != 4'd0) || in_loa);
      end
      stall_prev = out_valid && !out_ready;
      prev_r     = out_r;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_extra_output", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          ap = ap_q.pop_front();
          chk("drain_r", 64'(out_r), 64'(e));
          if (ap) exp_cnt = exp_cnt + 32'd1;
        end
      end
      @(negedge clk);
    end
    chk("stream_all_delivered", 64'(exp_q.size()), 64'd0);
    chk("stream_cnt", 64'(approx_cnt), 64'(exp_cnt));

    // Reset with transactions in flight
    in_a = 8'h5A; in_b = 8'hC3; in_mode = 4'b1111; in_loa = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_a = 8'h77; in_b = 8'h99;
    @(negedge clk);
    in_a = 8'h31; in_b = 8'hE4;
    rst  = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt", 64'(approx_cnt), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_cnt  = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_output", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    run_one("after_rst", 8'hA7, 8'h3C, 4'b0000, 1'b0);

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    chk("wrap_preload", 64'(approx_cnt), 64'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    run_one("wrap", 8'hE9, 8'h6D, 4'b0001, 1'b0);
    chk("wrap_zero", 64'(approx_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
